// File: rtl/tt_pkg.sv
// Shared types and limits for the truth-table checker.
package tt_pkg;

    localparam int unsigned TT_MAX_NIN  = 4;
    localparam int unsigned TT_MAX_NOUT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } tt_state_e;

endpackage : tt_pkg

// File: rtl/tt_row_compare.sv
// Combinational golden-row lookup and mismatch flags for one offered row.
module tt_row_compare
    import tt_pkg::*;
#(
    parameter int unsigned NIN  = 3,
    parameter int unsigned NOUT = 2
) (
    input  logic [NIN-1:0]             idx,
    input  logic [NIN-1:0]             row_in,
    input  logic [NOUT-1:0]            row_out,
    input  logic [(2**NIN)*NOUT-1:0]   expected,
    output logic                       mism,
    output logic                       seq_mism
);

    logic [NOUT-1:0] w_golden;

    assign w_golden = expected[int'(idx) * int'(NOUT) +: NOUT];
    assign mism     = (row_out != w_golden);
    assign seq_mism = (row_in != idx);

endmodule : tt_row_compare

// File: rtl/tt_checker.sv
// Sweeps all 2**NIN rows of a DUT truth table and scores them against EXPECTED.
// Optional row-order checking is enabled by defining TT_CHECKER_SEQ_CHECK_EN.
module tt_checker
    import tt_pkg::*;
#(
    parameter int unsigned                 NIN      = 3,
    parameter int unsigned                 NOUT     = 2,
    parameter logic [(2**NIN)*NOUT-1:0]    EXPECTED = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              row_valid,
    output logic              row_ready,
    input  logic [NIN-1:0]    row_in,
    input  logic [NOUT-1:0]   row_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [NIN:0]      err_count,
    output logic [NIN-1:0]    first_err_idx,
    output logic              first_err_valid,
    output logic              seq_err
);

    localparam int unsigned ROWS = 2**NIN;
    localparam int unsigned CW   = NIN + 1;

    tt_state_e       r_state;
    tt_state_e       w_next;
    logic            r_row_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [NIN-1:0]  r_idx;
    logic [CW-1:0]   r_err;
    logic [NIN-1:0]  r_first_idx;
    logic            r_first_valid;
    logic            r_seq_err;

    logic            w_accept;
    logic            w_last;
    logic            w_start;
    logic            w_mism_out;
    logic            w_seq_mism;
    logic            w_row_mism;
    logic            w_seq_flag;
    logic [CW-1:0]   w_err_next;

    tt_row_compare #(
        .NIN  (NIN),
        .NOUT (NOUT)
    ) u_cmp (
        .idx      (r_idx),
        .row_in   (row_in),
        .row_out  (row_out),
        .expected (EXPECTED),
        .mism     (w_mism_out),
        .seq_mism (w_seq_mism)
    );

    // A row whose index is wrong counts once, whatever its output says.
`ifdef TT_CHECKER_SEQ_CHECK_EN
    assign w_row_mism = w_mism_out | w_seq_mism;
    assign w_seq_flag = w_seq_mism;
`else
    logic w_unused_seq;
    assign w_unused_seq = w_seq_mism;
    assign w_row_mism   = w_mism_out;
    assign w_seq_flag   = 1'b0;
`endif

    assign w_accept = row_valid && r_row_ready;
    assign w_last   = w_accept && (r_idx == NIN'(ROWS - 1));
    assign w_start  = (r_state == IDLE) && start;

    // Saturating mismatch count including the row accepted this edge.
    always_comb begin
        w_err_next = r_err;
        if (w_accept && w_row_mism && (r_err != CW'(ROWS))) begin
            w_err_next = r_err + CW'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = COLLECT;
            COLLECT: if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they align with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_row_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_row_ready <= (w_next == COLLECT);
            r_busy      <= (w_next != IDLE);
            r_done      <= (w_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_err         <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
            r_seq_err     <= 1'b0;
            r_pass        <= 1'b0;
        end else if (w_start) begin
            r_idx         <= '0;
            r_err         <= '0;
            r_first_idx   <= '0;
            r_first_valid <= 1'b0;
            r_seq_err     <= 1'b0;
        end else if (w_accept) begin
            r_idx <= r_idx + NIN'(1);
            r_err <= w_err_next;
            if (w_row_mism && !r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_idx   <= r_idx;
            end
            if (w_seq_flag) begin
                r_seq_err <= 1'b1;
            end
            // pass is loaded alongside the DONE entry so it is valid with done.
            if (w_last) begin
                r_pass <= (w_err_next == '0);
            end
        end
    end

    assign row_ready       = r_row_ready;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err;
    assign first_err_idx   = r_first_idx;
    assign first_err_valid = r_first_valid;
    assign seq_err         = r_seq_err;

endmodule : tt_checker

// File: tb/tb_tt_checker.sv
// Scoreboard bench for tt_checker with a 3-input majority golden table.
`timescale 1ns/1ps
module tb_tt_checker;

    localparam int unsigned NIN  = 3;
    localparam int unsigned NOUT = 1;
    localparam logic [7:0]  EXP  = 8'b11101000;
`ifdef TT_CHECKER_SEQ_CHECK_EN
    localparam bit SEQ_EN = 1'b1;
`else
    localparam bit SEQ_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pass;
        logic [3:0] err;
        logic [2:0] fidx;
        logic       fvalid;
        logic       seq;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       row_valid = 1'b0;
    logic [2:0] row_in = '0;
    logic [0:0] row_out = '0;
    logic       row_ready, busy, done, pass, first_err_valid, seq_err;
    logic [3:0] err_count;
    logic [2:0] first_err_idx;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t sb[$];

    tt_checker #(.NIN(NIN), .NOUT(NOUT), .EXPECTED(EXP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row_valid(row_valid),
        .row_ready(row_ready), .row_in(row_in), .row_out(row_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_valid(first_err_valid),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    function automatic logic maj(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Reference scoring of one sweep straight from the golden table.
    function automatic res_t model(input int ord[8], input logic [7:0] flip);
        res_t r;
        logic o;
        bool_loop: begin end
        r = '0;
        for (int k = 0; k < 8; k++) begin
            o = maj(3'(ord[k])) ^ flip[k];
            if ((o != EXP[k]) || (SEQ_EN && ord[k] != k)) begin
                if (!r.fvalid) begin
                    r.fvalid = 1'b1;
                    r.fidx   = 3'(k);
                end
                r.err = r.err + 4'd1;
            end
            if (SEQ_EN && ord[k] != k) r.seq = 1'b1;
        end
        r.pass = (r.err == 4'd0);
        return r;
    endfunction

    // Drives one sweep; cycle 1 is the cycle start is presented in.
    task automatic drive_sweep(input int ord[8], input logic [7:0] flip,
                               input bit hold_start, input bit toggle,
                               output res_t got, output int done_cyc,
                               output int n_done, output int n_acc,
                               output logic pass_c2, output bit tmo);
        int k;
        int cyc;
        bit acc;
        k = 0; cyc = 1; done_cyc = 0; n_done = 0; n_acc = 0; tmo = 1'b0;
        got = '0; pass_c2 = 1'bx;
        sb.push_back(model(ord, flip));
        start     = 1'b1;
        row_valid = 1'b1;
        row_in    = 3'(ord[0]);
        row_out   = 1'(maj(row_in) ^ flip[0]);
        while (1) begin
            acc = row_valid && row_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin k++; n_acc++; end
            if (cyc == 2) pass_c2 = pass;
            if (done) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    got = {pass, err_count, first_err_idx, first_err_valid, seq_err};
                end
            end
            if (!hold_start || done_cyc != 0) start = 1'b0;
            if (k >= 8) begin
                row_valid = 1'b0;
            end else begin
                row_valid = toggle ? ~row_valid : 1'b1;
                row_in    = 3'(ord[k]);
                row_out   = 1'(maj(row_in) ^ flip[k]);
            end
            if (done_cyc != 0 && cyc >= done_cyc + 3) break;
            if (cyc > 80) begin tmo = 1'b1; break; end
        end
        start = 1'b0;
        row_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] outs;
        rst_n = 1'b0; start = 1'b1; row_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        outs = {row_ready, busy, done, pass, err_count, first_err_idx, first_err_valid, seq_err};
        n_cmp++;
        if (outs !== '0) begin
            n_err++; $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, row_ready, err_count} !== '0) begin
            n_err++; $display("FAIL idle_ignores_valid got busy=%b ready=%b err=%0d exp 0", busy, row_ready, err_count);
        end
        row_valid = 1'b0;
    endtask

    task automatic run_and_check(input string name, input int ord[8], input logic [7:0] flip,
                                 input bit hold_start, input bit toggle,
                                 input logic exp_pass_c2, input int exp_done_cyc);
        res_t got, exp;
        int dc, nd, na;
        logic pc2;
        bit tmo;
        drive_sweep(ord, flip, hold_start, toggle, got, dc, nd, na, pc2, tmo);
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_cmp++;
        if (tmo) begin n_err++; $display("FAIL %s_timeout got no done exp done", name); end
        n_cmp++;
        if (got !== exp) begin
            n_err++; $display("FAIL %s_result got pass=%b err=%0d fidx=%0d fv=%b seq=%b exp pass=%b err=%0d fidx=%0d fv=%b seq=%b",
                name, got.pass, got.err, got.fidx, got.fvalid, got.seq, exp.pass, exp.err, exp.fidx, exp.fvalid, exp.seq);
        end
        n_cmp++;
        if (nd !== 1 || na !== 8) begin
            n_err++; $display("FAIL %s_counts got done=%0d acc=%0d exp done=1 acc=8", name, nd, na);
        end
        n_cmp++;
        if (pc2 !== exp_pass_c2) begin
            n_err++; $display("FAIL %s_pass_hold got=%b exp=%b", name, pc2, exp_pass_c2);
        end
        if (exp_done_cyc != 0) begin
            n_cmp++;
            if (dc !== exp_done_cyc) begin
                n_err++; $display("FAIL %s_latency got=%0d exp=%0d", name, dc, exp_done_cyc);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || pass !== exp.pass) begin
            n_err++; $display("FAIL %s_after got busy=%b pass=%b exp busy=0 pass=%b", name, busy, pass, exp.pass);
        end
    endtask

    task automatic test_majority();
        int ord[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_and_check("v1", ord, 8'h00, 1'b0, 1'b0, 1'b0, 10);
    endtask

    task automatic test_single_err();
        int ord[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_and_check("v2", ord, 8'b0010_0000, 1'b0, 1'b0, 1'b1, 10);
    endtask

    task automatic test_two_err();
        int ord[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_and_check("v3", ord, 8'b0100_0100, 1'b0, 1'b0, 1'b0, 10);
    endtask

    task automatic test_out_of_order();
        int ord[8] = '{0, 1, 3, 2, 4, 5, 6, 7};
        run_and_check("v4", ord, 8'h00, 1'b0, 1'b0, 1'b0, 10);
        n_cmp++;
        if (seq_err !== SEQ_EN) begin
            n_err++; $display("FAIL v4_seq_err got=%b exp=%b", seq_err, SEQ_EN);
        end
    endtask

    task automatic test_all_wrong();
        int ord[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_and_check("all_wrong", ord, 8'hFF, 1'b0, 1'b0, 1'b0, 10);
    endtask

    task automatic test_reset_abort();
        int ord[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        int k;
        bit acc;
        bit seen_done;
        logic [13:0] outs;
        k = 0; seen_done = 1'b0;
        start = 1'b1; row_valid = 1'b1; row_in = 3'd0; row_out = 1'(maj(3'd0));
        for (int c = 0; c < 40 && k < 5; c++) begin
            acc = row_valid && row_ready;
            @(posedge clk); #1;
            if (acc) k++;
            start = 1'b0;
            if (done) seen_done = 1'b1;
            row_in = 3'(k); row_out = 1'(maj(3'(k)));
        end
        n_cmp++;
        if (k !== 5) begin n_err++; $display("FAIL v5_rows_before_abort got=%0d exp=5", k); end
        rst_n = 1'b0;
        #1;
        outs = {row_ready, busy, done, pass, err_count, first_err_idx, first_err_valid, seq_err};
        n_cmp++;
        if (outs !== '0) begin n_err++; $display("FAIL v5_reset_outputs got=%h exp=0", outs); end
        repeat (2) begin @(posedge clk); #1; if (done) seen_done = 1'b1; end
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; if (done || busy) seen_done = 1'b1; end
        n_cmp++;
        if (seen_done !== 1'b0) begin n_err++; $display("FAIL v5_no_done got=1 exp=0"); end
        row_valid = 1'b0;
        run_and_check("v5_restart", ord, 8'h00, 1'b0, 1'b0, 1'b0, 10);
    endtask

    task automatic test_start_held();
        int ord[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_and_check("v6", ord, 8'h00, 1'b1, 1'b1, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        int ord[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        run_and_check("b2b_a", ord, 8'b1000_0000, 1'b0, 1'b0, 1'b1, 10);
        run_and_check("b2b_b", ord, 8'h00, 1'b0, 1'b0, 1'b0, 10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_majority();
        test_single_err();
        test_two_err();
        test_out_of_order();
        test_all_wrong();
        test_reset_abort();
        test_start_held();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tt_checker

// File: doc/tt_checker.md
TT_CHECKER -- requirements
Module: tt_checker

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NIN, 3, DUT input width; legal range 1..4.
- NOUT, 2, DUT output width; legal range 1..4.
- EXPECTED, 0, packed golden table of (2**NIN)*NOUT bits. Row r occupies EXPECTED[r*NOUT +: NOUT].

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: reset.
- start, in, 1: begin a sweep.
- row_valid, in, 1: a row is offered.
- row_ready, out, 1: the block can accept a row.
- row_in, in, NIN: DUT input vector for the row.
- row_out, in, NOUT: DUT output for the row.
- busy, out, 1: a sweep is in progress.
- done, out, 1: one-cycle end-of-sweep pulse.
- pass, out, 1: the last sweep had no mismatch.
- err_count, out, NIN+1: mismatches in the last sweep.
- first_err_idx, out, NIN: row index of the first mismatch.
- first_err_valid, out, 1: first_err_idx is meaningful.
- seq_err, out, 1: an out-of-order row was seen.

REQ-003 One clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-004 FSM states SHALL be IDLE, COLLECT and DONE.
- IDLE to COLLECT: start=1.
- COLLECT to DONE: the cycle after the row with index 2**NIN-1 is accepted.
- DONE to IDLE: unconditionally, after one cycle.

REQ-005 A row SHALL be accepted only on a clock edge where row_valid and row_ready are both 1. row_ready=1 only in COLLECT. row_valid in IDLE or DONE SHALL be ignored.

REQ-006 A row index counter SHALL clear to 0 on entry to COLLECT and increment by 1 per accepted row.

REQ-007 For each accepted row at index idx, the block SHALL compare row_out with EXPECTED[idx*NOUT +: NOUT]. A mismatch SHALL increment err_count in the same edge.

REQ-008 On the first mismatch of a sweep, the block SHALL load first_err_idx=idx and set first_err_valid=1. Later mismatches SHALL NOT change first_err_idx.

REQ-009 err_count SHALL saturate at 2**NIN, so it never wraps. At most 2**NIN rows are accepted, so saturation is a safety bound only.

REQ-010 done=1 exactly in DONE. On the same cycle, pass=(err_count==0) SHALL be registered. pass holds until the next DONE.

REQ-011 busy=1 in COLLECT and DONE.

REQ-012 start while busy SHALL be ignored.

REQ-013 Entering COLLECT SHALL clear err_count, first_err_valid, first_err_idx and seq_err. pass SHALL keep its previous value until DONE.

REQ-014 Latency SHALL be:
- start to row_ready: 1 cycle.
- last accepted row to done: 1 cycle.
- Total sweep with row_valid held high: 2**NIN+2 cycles.

REQ-015 If start and row_valid are both 1 in IDLE, the row SHALL NOT be accepted.

Reset
REQ-016 While rst_n=0, the block SHALL be in IDLE with all outputs 0, except pass=0 and row_ready=0.

REQ-017 If rst_n is asserted mid-sweep, the sweep SHALL be aborted with no done pulse. After release, the block SHALL wait in IDLE for start.

Configuration
REQ-018 Macro TT_CHECKER_SEQ_CHECK_EN:
- Defined: for an accepted row with row_in != idx, seq_err SHALL latch to 1 and the row SHALL count as one mismatch. This is counted once, even if row_out also differs.
- Not defined: row_in SHALL be ignored and seq_err SHALL be tied to 0.

Structure
REQ-020 Shared package tt_pkg SHALL hold:
- the state enum {IDLE, COLLECT, DONE};
- constant TT_MAX_NIN=4;
- constant TT_MAX_NOUT=4.

REQ-021 One sub-module, tt_row_compare, SHALL implement the combinational golden-row selection and the mismatch flag. Its inputs are idx, row_in, row_out and EXPECTED; its outputs are mism and seq_mism.

Verification
REQ-022 The bench SHALL cover these directed scenarios. V1–V4 use NIN=3, NOUT=1, EXPECTED=8'b11101000 (3-input majority function):
- V1: majority DUT, rows 0..7 in order, row_valid held high → done at cycle 10 after start, pass=1, err_count=0, first_err_valid=0.
- V2: row 5 output forced to 0 → pass=0, err_count=1, first_err_idx=5, first_err_valid=1.
- V3: rows 2 and 6 both wrong → err_count=2, first_err_idx=2.
- V4: TT_CHECKER_SEQ_CHECK_EN defined, rows sent 0,1,3,2,4..7 with correct outputs for the sent row_in → seq_err=1, err_count=2, first_err_idx=2.
- V5: rst_n pulsed low after row 4 → no done pulse, all outputs 0. A new start then runs a full sweep to pass=1.
- V6: start held high during a sweep, and row_valid toggled 1/0 → no restart, exactly 8 acceptances, done once.
